// File: rtl/falling_object_bank.sv
// Multi-slot falling-object game core: spawns objects at LFSR-random columns,
// drops them once per frame, and scores catches against the tray window.
module falling_object_bank #(
  parameter int          N_OBJ        = 4,
  parameter int          SPEED        = 2,
  parameter int          CATCH_Y      = 440,
  parameter int          BOTTOM_Y     = 479,
  parameter int          TRAY_HALF    = 32,
  parameter int          X_OFFSET     = 64,
  parameter int          SPAWN_PERIOD = 60,
  parameter int          LIVES        = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_tick,
  input  logic                  start,
  input  logic [9:0]            tray_position,
  output logic [10*N_OBJ-1:0]   obj_x,
  output logic [10*N_OBJ-1:0]   obj_y,
  output logic [N_OBJ-1:0]      obj_active,
  output logic [15:0]           score,
  output logic [2:0]            lives,
  output logic                  game_over,
  output logic                  catch_pulse,
  output logic                  miss_pulse,
  output logic                  busy
);

  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OBJ - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [10:0]      SPEED_L  = 11'(SPEED);
  localparam logic [10:0]      CATCH_L  = 11'(CATCH_Y);
  localparam logic [10:0]      BOTTOM_L = 11'(BOTTOM_Y);
  localparam logic [9:0]       HALF_L   = 10'(TRAY_HALF);
  localparam logic [10:0]      HALF_W   = 11'(TRAY_HALF);
  localparam logic [10:0]      X_MAX_W  = 11'd639;
  localparam logic [9:0]       XOFF_L   = 10'(X_OFFSET);
  localparam logic [2:0]       LIVES_L  = 3'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_UPDATE = 3'd2,
    S_SPAWN  = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] cur);
    return (cur == 16'hFFFF) ? cur : (cur + 16'd1);
  endfunction

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [9:0]         x_r [N_OBJ];
  logic [9:0]         x_s [N_OBJ];
  logic [9:0]         y_r [N_OBJ];
  logic [9:0]         y_s [N_OBJ];
  logic [N_OBJ-1:0]   act_r, act_s;
  logic [15:0]        score_r, score_s;
  logic [2:0]         lives_r, lives_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               req_r, req_s;
  logic               catch_r, catch_s;
  logic               miss_r, miss_s;
  logic               busy_r, over_r;
  logic [15:0]        lfsr_r;

  logic [9:0]         slot_x_s, slot_y_s;
  logic [10:0]        ny_s, tray_hi_s;
  logic [9:0]         tray_min_s, tray_max_s, spawn_x_s;
  logic               catch_hit_s, free_found_s;
  logic [IDX_W-1:0]   free_idx_s;

  assign slot_x_s    = x_r[idx_r];
  assign slot_y_s    = y_r[idx_r];
  assign ny_s        = {1'b0, slot_y_s} + SPEED_L;
  assign tray_hi_s   = {1'b0, tray_position} + HALF_W;
  assign tray_min_s  = (tray_position < HALF_L) ? 10'd0 : (tray_position - HALF_L);
  assign tray_max_s  = (tray_hi_s > X_MAX_W) ? 10'd639 : tray_hi_s[9:0];
  assign spawn_x_s   = {1'b0, lfsr_r[8:0]} + XOFF_L;
  // A catch only counts on the frame the object crosses the catch line.
  assign catch_hit_s = ({1'b0, slot_y_s} < CATCH_L) && (ny_s >= CATCH_L) &&
                       (slot_x_s >= tray_min_s) && (slot_x_s <= tray_max_s);

  // Lowest-index free slot for the next spawn
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = {IDX_W{1'b0}};
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (!act_r[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = IDX_W'(i);
      end else begin
      end
    end
  end

  // Next-state and next-value logic for the game sequencer
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    x_s     = x_r;
    y_s     = y_r;
    act_s   = act_r;
    score_s = score_r;
    lives_s = lives_r;
    cnt_s   = cnt_r;
    req_s   = req_r;
    catch_s = 1'b0;
    miss_s  = 1'b0;
    case (state_r)
      S_IDLE, S_OVER: begin
        if (start) begin
          for (int i = 0; i < N_OBJ; i++) begin
            x_s[i] = 10'd0;
            y_s[i] = 10'd0;
          end
          act_s   = {N_OBJ{1'b0}};
          score_s = 16'd0;
          lives_s = LIVES_L;
          cnt_s   = {CNT_W{1'b0}};
          req_s   = 1'b0;
          state_s = S_WAIT;
        end else begin
          state_s = state_r;
        end
      end
      S_WAIT: begin
        if (frame_tick) begin
          if (cnt_r == CNT_LAST) begin
            cnt_s = {CNT_W{1'b0}};
            req_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
          idx_s   = {IDX_W{1'b0}};
          state_s = S_UPDATE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_UPDATE: begin
        if (act_r[idx_r]) begin
          if (catch_hit_s) begin
            act_s[idx_r] = 1'b0;
            score_s      = sat_inc16(score_r);
            catch_s      = 1'b1;
          end else if (ny_s >= BOTTOM_L) begin
            act_s[idx_r] = 1'b0;
            lives_s      = (lives_r != 3'd0) ? (lives_r - 3'd1) : 3'd0;
            miss_s       = 1'b1;
          end else begin
            y_s[idx_r] = ny_s[9:0];
          end
        end else begin
        end
        // lives_s already includes any miss from the final slot.
        if (idx_r == IDX_LAST) begin
          if (lives_s == 3'd0) begin
            act_s   = {N_OBJ{1'b0}};
            state_s = S_OVER;
          end else if (req_r) begin
            state_s = S_SPAWN;
          end else begin
            state_s = S_WAIT;
          end
        end else begin
          idx_s = idx_r + IDX_ONE;
        end
      end
      S_SPAWN: begin
        if (free_found_s) begin
          x_s[free_idx_s]   = spawn_x_s;
          y_s[free_idx_s]   = 10'd0;
          act_s[free_idx_s] = 1'b1;
        end else begin
        end
        req_s   = 1'b0;
        state_s = S_WAIT;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Sequencer, slot storage, LFSR and registered status outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= S_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      for (int i = 0; i < N_OBJ; i++) begin
        x_r[i] <= 10'd0;
        y_r[i] <= 10'd0;
      end
      act_r   <= {N_OBJ{1'b0}};
      score_r <= 16'd0;
      lives_r <= 3'd0;
      cnt_r   <= {CNT_W{1'b0}};
      req_r   <= 1'b0;
      catch_r <= 1'b0;
      miss_r  <= 1'b0;
      busy_r  <= 1'b0;
      over_r  <= 1'b0;
      lfsr_r  <= LFSR_SEED;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      x_r     <= x_s;
      y_r     <= y_s;
      act_r   <= act_s;
      score_r <= score_s;
      lives_r <= lives_s;
      cnt_r   <= cnt_s;
      req_r   <= req_s;
      catch_r <= catch_s;
      miss_r  <= miss_s;
      busy_r  <= (state_s == S_UPDATE) || (state_s == S_SPAWN);
      over_r  <= (state_s == S_OVER);
      lfsr_r  <= lfsr_next(lfsr_r);
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_pack
    assign obj_x[10*g +: 10] = x_r[g];
    assign obj_y[10*g +: 10] = y_r[g];
  end

  assign obj_active  = act_r;
  assign score       = score_r;
  assign lives       = lives_r;
  assign game_over   = over_r;
  assign catch_pulse = catch_r;
  assign miss_pulse  = miss_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_falling_object_bank.sv
// Bench for falling_object_bank: frame-level game model checked every cycle,
// plus directed scenarios (spawn, catch, misses to game over, restart, reset).
module tb_falling_object_bank;

  localparam int          N      = 2;
  localparam int          P      = 2;
  localparam int          SPEED  = 2;
  localparam int          CATCH  = 440;
  localparam int          BOTTOM = 479;
  localparam int          HALF   = 32;
  localparam int          XOFF   = 64;
  localparam int          LIV    = 3;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic          Clk = 1'b0;
  logic          Reset, frame_tick, start;
  logic [9:0]    tray_position;
  logic [19:0]   obj_x, obj_y;
  logic [1:0]    obj_active;
  logic [15:0]   score;
  logic [2:0]    lives;
  logic          game_over, catch_pulse, miss_pulse, busy;

  falling_object_bank #(
    .N_OBJ(N), .SPEED(SPEED), .CATCH_Y(CATCH), .BOTTOM_Y(BOTTOM),
    .TRAY_HALF(HALF), .X_OFFSET(XOFF), .SPAWN_PERIOD(P), .LIVES(LIV),
    .LFSR_SEED(SEED)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
    .tray_position(tray_position), .obj_x(obj_x), .obj_y(obj_y),
    .obj_active(obj_active), .score(score), .lives(lives),
    .game_over(game_over), .catch_pulse(catch_pulse),
    .miss_pulse(miss_pulse), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Game model: phase 0 idle, 1 playing, 2 over. A whole frame is resolved
  // at the accepted tick; fc counts cycles since then to time busy/pulses.
  int          m_x [N];
  int          m_y [N];
  bit          m_act [N];
  int          m_score, m_lives, m_phase, m_cnt;
  bit          m_req;
  logic [15:0] m_lfsr;
  int          fc, flen;
  bit          f_spawn;
  bit          e_c [N];
  bit          e_m [N];

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_x[k] = 0; m_y[k] = 0; m_act[k] = 0; e_c[k] = 0; e_m[k] = 0;
    end
    m_score = 0; m_lives = 0; m_phase = 0; m_cnt = 0; m_req = 0;
    m_lfsr = SEED; fc = 0; flen = 0; f_spawn = 0;
  endtask

  task automatic model_start();
    for (int k = 0; k < N; k++) begin
      m_x[k] = 0; m_y[k] = 0; m_act[k] = 0;
    end
    m_score = 0; m_lives = LIV; m_phase = 1; m_cnt = 0; m_req = 0; fc = 0;
  endtask

  task automatic model_frame();
    int tmin, tmax, ny;
    logic [15:0] sl;
    bit placed;
    if (m_cnt == P - 1) begin m_cnt = 0; m_req = 1; end
    else m_cnt = m_cnt + 1;
    tmin = int'(tray_position) - HALF;
    if (tmin < 0) tmin = 0;
    tmax = int'(tray_position) + HALF;
    if (tmax > 639) tmax = 639;
    for (int k = 0; k < N; k++) begin
      e_c[k] = 0; e_m[k] = 0;
      if (m_act[k]) begin
        ny = m_y[k] + SPEED;
        if (m_y[k] < CATCH && ny >= CATCH && m_x[k] >= tmin && m_x[k] <= tmax) begin
          m_act[k] = 0; e_c[k] = 1;
          if (m_score < 65535) m_score = m_score + 1;
        end else if (ny >= BOTTOM) begin
          m_act[k] = 0; e_m[k] = 1;
          if (m_lives > 0) m_lives = m_lives - 1;
        end else begin
          m_y[k] = ny;
        end
      end
    end
    f_spawn = 0;
    if (m_lives == 0) begin
      m_phase = 2;
      for (int k = 0; k < N; k++) m_act[k] = 0;
    end else if (m_req) begin
      f_spawn = 1; m_req = 0;
      // The spawn cycle comes N+1 clocks after the tick cycle.
      sl = m_lfsr;
      for (int s = 0; s < N + 1; s++) sl = lfsr_adv(sl);
      placed = 0;
      for (int k = 0; k < N; k++) begin
        if (!placed && !m_act[k]) begin
          placed = 1; m_act[k] = 1; m_y[k] = 0; m_x[k] = int'(sl[8:0]) + XOFF;
        end
      end
    end
    flen = f_spawn ? N + 2 : N + 1;
    fc = 1;
  endtask

  initial begin
    bit at_rest, acc_start, acc_tick;
    model_reset();
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) model_reset();
      else begin
        at_rest   = (fc == 0) || (fc == flen);
        acc_start = start && (m_phase != 1) && at_rest;
        acc_tick  = frame_tick && (m_phase == 1) && at_rest;
        if (fc != 0) fc = (fc == flen) ? 0 : fc + 1;
        if (acc_start) model_start();
        else if (acc_tick) model_frame();
        m_lfsr = lfsr_adv(m_lfsr);
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    logic [19:0] ex, ey;
    logic [1:0]  ea;
    bit          eb, ec, em;
    forever begin
      @(negedge Clk);
      eb = ((fc >= 1) && (fc <= N)) || ((fc == N + 1) && f_spawn);
      ec = 0; em = 0;
      if (fc >= 2 && fc <= N + 1) begin ec = e_c[fc-2]; em = e_m[fc-2]; end
      check("busy", busy, eb);
      check("catch_pulse", catch_pulse, ec);
      check("miss_pulse", miss_pulse, em);
      if (fc == 0 || fc == flen) begin
        for (int k = 0; k < N; k++) begin
          ex[10*k +: 10] = 10'(m_x[k]);
          ey[10*k +: 10] = 10'(m_y[k]);
          ea[k] = m_act[k];
        end
        check("obj_x", obj_x, ex);
        check("obj_y", obj_y, ey);
        check("obj_active", obj_active, ea);
        check("score", score, 16'(m_score));
        check("lives", lives, 3'(m_lives));
        check("game_over", game_over, m_phase == 2);
      end
    end
  end

  int last_busy, last_catch, last_miss;

  task automatic frame(input bit extra = 1'b0);
    last_busy = 0; last_catch = 0; last_miss = 0;
    @(negedge Clk);
    frame_tick = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge Clk);
      frame_tick = extra && (c == 2);
      start      = extra && (c == 1);
      last_busy  += int'(busy);
      last_catch += int'(catch_pulse);
      last_miss  += int'(miss_pulse);
    end
    frame_tick = 1'b0;
    start      = 1'b0;
  endtask

  task automatic start_game();
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at t=%0t, want finish", $time);
    $fatal(1);
  end

  initial begin
    bit found;
    Reset = 1'b1; frame_tick = 1'b0; start = 1'b0; tray_position = 10'd0;
    repeat (3) @(negedge Clk);
    check("rst_score", score, 64'd0);
    check("rst_lives", lives, 64'd0);
    check("rst_active", obj_active, 64'd0);
    check("rst_game_over", game_over, 64'd0);
    Reset = 1'b0;

    repeat (3) frame();
    check("idle_tick_busy", last_busy, 64'd0);
    check("idle_tick_active", obj_active, 64'd0);

    start_game();
    check("start_lives", lives, 64'd3);
    frame();
    check("busy_len_nospawn", last_busy, 64'd2);
    frame();
    check("busy_len_spawn", last_busy, 64'd3);
    check("spawn_active", obj_active, 64'd1);
    check("spawn_y", obj_y[9:0], 64'd0);
    check("spawn_x_range", (obj_x[9:0] >= 10'd64) && (obj_x[9:0] <= 10'd575), 64'd1);
    frame();
    check("fall_y", obj_y[9:0], 64'd2);
    repeat (3) frame();
    check("both_full_active", obj_active, 64'd3);
    check("full_spawn_busy", last_busy, 64'd3);
    check("slot0_y", obj_y[9:0], 64'd8);
    check("slot1_y", obj_y[19:10], 64'd4);

    found = 0;
    for (int f = 0; f < 300 && !found; f++) begin
      if (m_act[0] && m_y[0] == 438) found = 1;
      else frame();
    end
    check("catch_reach", found, 64'd1);
    tray_position = 10'(m_x[0] + 20);
    frame();
    check("catch_seen", last_catch, 64'd1);
    check("catch_score", score, 64'd1);
    check("catch_lives", lives, 64'd3);
    tray_position = 10'd0;

    found = 0;
    for (int f = 0; f < 300 && !found; f++) begin
      if (m_lives < 3) found = 1;
      else frame();
    end
    check("miss_reach", found, 64'd1);
    check("miss_seen", last_miss, 64'd1);
    check("miss_lives", lives, 64'd2);

    found = 0;
    for (int f = 0; f < 600 && !found; f++) begin
      if (m_phase == 2) found = 1;
      else frame();
    end
    check("over_reach", found, 64'd1);
    check("over_flag", game_over, 64'd1);
    check("over_lives", lives, 64'd0);
    check("over_active", obj_active, 64'd0);
    check("over_score", score, 64'd1);
    frame();
    check("over_tick_busy", last_busy, 64'd0);

    start_game();
    check("restart_lives", lives, 64'd3);
    check("restart_score", score, 64'd0);
    check("restart_flag", game_over, 64'd0);
    check("restart_active", obj_active, 64'd0);
    frame();
    frame(1'b1);
    check("ignored_inputs_active", obj_active, 64'd1);
    check("ignored_inputs_busy", last_busy, 64'd3);

    @(negedge Clk); frame_tick = 1'b1;
    @(negedge Clk); frame_tick = 1'b0;
    @(negedge Clk);
    check("mid_update_busy", busy, 64'd1);
    #2 Reset = 1'b1;
    #1;
    check("midrst_active", obj_active, 64'd0);
    check("midrst_x", obj_x, 64'd0);
    check("midrst_y", obj_y, 64'd0);
    check("midrst_lives", lives, 64'd0);
    check("midrst_busy", busy, 64'd0);
    check("midrst_score", score, 64'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    frame();
    check("post_rst_idle_busy", last_busy, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/falling_object_bank.md
Name: falling_object_bank

Overview:
- Parametrised multi-object successor to the single-object catch-game controller.
- Manages N_OBJ independent falling objects with LFSR-random spawn columns, tray-window catch detection, score and lives.
- Ends the game on zero lives.
- Sits between the frame-tick source, the tray controller (tray_position) and the colour mapper, which consumes obj_x/obj_y/obj_active.

Parameters:
N_OBJ, 4, number of object slots (1..8)
SPEED, 2, pixels added to y per frame
CATCH_Y, 440, y line where the tray catches
BOTTOM_Y, 479, y at or past which an object is missed
TRAY_HALF, 32, half-width of the tray catch window
X_OFFSET, 64, added to the 9-bit random value to form spawn x
SPAWN_PERIOD, 60, frames between spawn attempts (>=1)
LIVES, 3, lives at game start (1..7)
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous active-high reset
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  one-cycle pulse; starts or restarts a game
tray_position  in  10  tray centre x
obj_x  out  10*N_OBJ  packed x per slot, slot i at [10i+9:10i]
obj_y  out  10*N_OBJ  packed y per slot
obj_active  out  N_OBJ  slot occupied
score  out  16  caught count, saturating at 16'hFFFF
lives  out  3  remaining lives
game_over  out  1  high in OVER state
catch_pulse  out  1  one cycle per catch
miss_pulse  out  1  one cycle per miss
busy  out  1  high in UPDATE or SPAWN

Behaviour:
Reset:
- state=IDLE; all obj_x, obj_y and obj_active = 0; score = 0; lives = 0.
- game_over, pulses and busy = 0; LFSR = LFSR_SEED; spawn_cnt = 0.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11.
- Shifts every Clk in every state.
- rand9 = lfsr[8:0]; spawn x = rand9 + X_OFFSET (10-bit, range 64..575 at default).

Tray window:
- tray_min = tray_position - TRAY_HALF, clamped at 0.
- tray_max = tray_position + TRAY_HALF, clamped at 639.
- Sampled combinationally in the cycle each slot is processed.

States and transitions:
- IDLE --start--> WAIT.
- WAIT --frame_tick--> UPDATE with idx = 0.
- UPDATE: processes slot idx in one cycle, idx++. After slot N_OBJ-1:
  - if lives == 0: go to OVER;
  - else if spawn_req: go to SPAWN;
  - else: go to WAIT.
- SPAWN: 1 cycle, then WAIT.
- OVER --start--> WAIT.
- start is ignored in UPDATE/SPAWN.
- frame_tick is ignored unless in WAIT; it is not queued.

Start (from IDLE or OVER):
- Clear all slots; score = 0; lives = LIVES; spawn_cnt = 0; game_over = 0.

Per-frame spawn counter (on each accepted frame_tick in WAIT):
- if spawn_cnt == SPAWN_PERIOD-1: spawn_cnt = 0 and set spawn_req;
- else: spawn_cnt++.

Per-slot update (active slots only; inactive slots untouched). Let ny = y + SPEED:
- Catch: y < CATCH_Y and ny >= CATCH_Y and tray_min <= x <= tray_max (inclusive) -> active = 0, score++ (saturating), catch_pulse for this cycle.
- Else miss: ny >= BOTTOM_Y -> active = 0, lives-- (floor 0), miss_pulse.
- Else: y = ny.
- An object not caught at the CATCH_Y crossing keeps falling until the miss.
- Cleared slots retain their last x/y values.

SPAWN:
- Lowest-index inactive slot gets x = rand9 + X_OFFSET, y = 0, active = 1.
- spawn_req cleared.
- No free slot: request dropped, no state change.

OVER:
- All obj_active = 0 on entry; game_over = 1; score and lives held.

Pulses:
- One-cycle; consecutive slots may produce back-to-back pulses.

Reset mid-UPDATE:
- Immediate return to the reset values above; no partial-scan effects survive.

Test Plan:
- Reset asserted then released -> state IDLE, score=0, lives=0, obj_active=0, game_over=0; frame_ticks alone cause no change.
- N_OBJ=2, SPAWN_PERIOD=2: start, 2 frame_ticks -> after 2nd tick, busy is high for N_OBJ+1 = 3 cycles. Slot0 active, y=0, x = lfsr[8:0]+64 sampled in the SPAWN cycle. Next tick -> y=2.
- Catch: tray_position=320, object x=300, y=438 -> next frame: catch_pulse for 1 cycle, score 0->1, slot0 inactive, lives unchanged.
- Miss: tray_position=600, object x=100 -> passes 440 with y=440, at y=478 next frame: miss_pulse, lives 3->2, slot cleared.
- Three misses with LIVES=3 -> lives=0, state OVER at end of scan, game_over=1, all inactive. start -> lives=3, score=0, game_over=0.
- Both slots full when spawn_req fires -> no slot changes; Reset asserted mid-UPDATE (idx=1) -> all outputs at reset values the same cycle.
